// File: rtl/execute_stage_md.sv
// execute_stage_md: RV32 execute stage with operand forwarding, single-cycle ALU,
// branch-target adder and an iterative RISC-V M-extension multiply/divide unit.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   rd1_e_i, rd2_e_i             register-file operands
//   pc_e_i, imm_ext_e_i          PC and extended immediate
//   result_m_i, result_w_i       forwarded MEM / WB results
//   forward1_e_i, forward2_e_i   00 regfile, 01 MEM, 10 WB, 11 zero
//   alu_src_e_i                  src2 select, 1 = immediate
//   alu_control_e_i              0 ADD 1 SUB 2 AND 3 OR 4 XOR 5 SLT 6 SLTU 7 SLL 8 SRL 9 SRA, else pass src2
//   md_en_e_i, md_op_e_i         M-extension op request and funct3
//   flush_e_i                    kill instruction in EX
//   alu_result_e_o               ALU result, or M-unit result in DONE
//   write_data_e_o               forwarded rs2 (store data)
//   pc_target_e_o                pc_e_i + imm_ext_e_i
//   zero_e_o                     src1 == src2
//   stall_e_o                    freeze IF/ID/EX while the M unit works
//
// Optional macro EXEC_MD_EARLY_OUT_EN: trivial M ops (divide by zero, multiply by
// zero, signed MIN / -1) skip the iterations and finish in two cycles.
module execute_stage_md #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] rd1_e_i,
    input  logic [DATA_WIDTH-1:0] rd2_e_i,
    input  logic [DATA_WIDTH-1:0] pc_e_i,
    input  logic [DATA_WIDTH-1:0] imm_ext_e_i,
    input  logic [DATA_WIDTH-1:0] result_m_i,
    input  logic [DATA_WIDTH-1:0] result_w_i,
    input  logic [1:0]            forward1_e_i,
    input  logic [1:0]            forward2_e_i,
    input  logic                  alu_src_e_i,
    input  logic [3:0]            alu_control_e_i,
    input  logic                  md_en_e_i,
    input  logic [2:0]            md_op_e_i,
    input  logic                  flush_e_i,
    output logic [DATA_WIDTH-1:0] alu_result_e_o,
    output logic [DATA_WIDTH-1:0] write_data_e_o,
    output logic [DATA_WIDTH-1:0] pc_target_e_o,
    output logic                  zero_e_o,
    output logic                  stall_e_o
);
    localparam int W   = DATA_WIDTH;
    localparam int SHW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t r_state, w_next;

    logic [W-1:0]         w_src1, w_src2, w_wd, w_alu, w_m1, w_m2, w_md;
    logic                 w_sgn1, w_sgn2, w_n1, w_n2, w_bz, w_accept, w_early, w_stall;
    logic [W:0]           w_sum, w_sh, w_dif;
    logic [2*W-1:0]       w_pfix;
    logic [W-1:0]         r_a, r_hi, r_lo;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [2:0]           r_op;
    logic                 r_neg, r_n1, r_bz;

    always_comb begin
        w_src1 = forward1_e_i == 2'b00 ? rd1_e_i : forward1_e_i == 2'b01 ? result_m_i :
                 forward1_e_i == 2'b10 ? result_w_i : '0;
        w_wd   = forward2_e_i == 2'b00 ? rd2_e_i : forward2_e_i == 2'b01 ? result_m_i :
                 forward2_e_i == 2'b10 ? result_w_i : '0;
        w_src2 = alu_src_e_i ? imm_ext_e_i : w_wd;
    end

    assign write_data_e_o = w_wd;
    assign pc_target_e_o  = pc_e_i + imm_ext_e_i;
    assign zero_e_o       = w_src1 == w_src2;

    always_comb begin
        case (alu_control_e_i)
            4'd0:    w_alu = w_src1 + w_src2;
            4'd1:    w_alu = w_src1 - w_src2;
            4'd2:    w_alu = w_src1 & w_src2;
            4'd3:    w_alu = w_src1 | w_src2;
            4'd4:    w_alu = w_src1 ^ w_src2;
            4'd5:    w_alu = {{(W-1){1'b0}}, $signed(w_src1) < $signed(w_src2)};
            4'd6:    w_alu = {{(W-1){1'b0}}, w_src1 < w_src2};
            4'd7:    w_alu = w_src1 << w_src2[SHW-1:0];
            4'd8:    w_alu = w_src1 >> w_src2[SHW-1:0];
            4'd9:    w_alu = $signed(w_src1) >>> w_src2[SHW-1:0];
            default: w_alu = w_src2;
        endcase
    end

    // Operand signedness by funct3: only MULHU/DIVU/REMU treat src1 as unsigned,
    // MULHSU additionally treats src2 as unsigned.
    always_comb begin
        w_sgn1   = md_op_e_i[2] ? ~md_op_e_i[0] : md_op_e_i[1:0] != 2'b11;
        w_sgn2   = md_op_e_i[2] ? ~md_op_e_i[0] : ~md_op_e_i[1];
        w_n1     = w_sgn1 & w_src1[W-1];
        w_n2     = w_sgn2 & w_src2[W-1];
        w_m1     = w_n1 ? -w_src1 : w_src1;
        w_m2     = w_n2 ? -w_src2 : w_src2;
        w_bz     = w_src2 == '0;
        w_accept = r_state == IDLE & md_en_e_i & ~flush_e_i;
    end

`ifdef EXEC_MD_EARLY_OUT_EN
    assign w_early = md_op_e_i[2]
                   ? w_bz | (w_sgn1 & w_src1 == {1'b1, {(W-1){1'b0}}} & w_src2 == '1)
                   : w_src1 == '0 | w_bz;
`else
    assign w_early = 1'b0;
`endif

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            IDLE: if (w_accept) begin
                w_stall = 1'b1;
                w_next  = w_early ? DONE : BUSY;
            end
            BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == CNT_WIDTH'(1)) w_next = DONE;
            end
            default: w_next = IDLE;
        endcase
        if (flush_e_i) begin
            w_next  = IDLE;
            w_stall = 1'b0;
        end
    end

    assign stall_e_o = w_stall;

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // Multiply: {r_hi,r_lo} is a right-shifting product with the multiplier in r_lo.
    // Divide: {r_hi,r_lo} is a left-shifting remainder:quotient with the dividend in r_lo.
    always_comb begin
        w_sum  = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_a} : '0);
        w_sh   = {r_hi, r_lo[W-1]};
        w_dif  = w_sh - {1'b0, r_a};
        w_pfix = r_neg ? -{r_hi, r_lo} : {r_hi, r_lo};
        w_md   = ~r_op[2] ? (r_op[1:0] == 2'b00 ? w_pfix[W-1:0] : w_pfix[2*W-1:W]) :
                 r_op[1]  ? (r_n1 ? -r_hi : r_hi) :
                 r_bz     ? '1 : (r_neg ? -r_lo : r_lo);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
            r_a   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_op  <= '0;
            r_neg <= 1'b0;
            r_n1  <= 1'b0;
            r_bz  <= 1'b0;
        end else if (w_accept) begin
            r_cnt <= CNT_WIDTH'(W);
            r_op  <= md_op_e_i;
            r_neg <= w_n1 ^ w_n2;
            r_n1  <= w_n1;
            r_bz  <= w_bz;
            r_a   <= md_op_e_i[2] ? w_m2 : w_m1;
            // Early-out preloads the finished accumulator so DONE needs no special path.
            r_hi  <= (w_early & md_op_e_i[2] & w_bz) ? w_m1 : '0;
            r_lo  <= (w_early & ~md_op_e_i[2]) ? '0 : md_op_e_i[2] ? w_m1 : w_m2;
        end else if (r_state == BUSY) begin
            r_cnt <= r_cnt - CNT_WIDTH'(1);
            if (r_op[2]) begin
                r_hi <= w_dif[W] ? w_sh[W-1:0] : w_dif[W-1:0];
                r_lo <= {r_lo[W-2:0], ~w_dif[W]};
            end else begin
                r_hi <= w_sum[W:1];
                r_lo <= {w_sum[0], r_lo[W-1:1]};
            end
        end
    end

    assign alu_result_e_o = r_state == DONE ? w_md : w_alu;
endmodule

// File: tb/tb_execute_stage_md.sv
// tb_execute_stage_md: directed and randomized checks of execute_stage_md against a reference model.
module tb_execute_stage_md;
    localparam int W = 32;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic [31:0] rd1_e_i = '0, rd2_e_i = '0, pc_e_i = '0, imm_ext_e_i = '0;
    logic [31:0] result_m_i = '0, result_w_i = '0;
    logic [1:0]  forward1_e_i = '0, forward2_e_i = '0;
    logic        alu_src_e_i = 1'b0, md_en_e_i = 1'b0, flush_e_i = 1'b0;
    logic [3:0]  alu_control_e_i = '0;
    logic [2:0]  md_op_e_i = '0;
    logic [31:0] alu_result_e_o, write_data_e_o, pc_target_e_o;
    logic        zero_e_o, stall_e_o;
    int total = 0, bad = 0;

    execute_stage_md dut (
        .clk_i(clk_i), .rst_i(rst_i), .rd1_e_i(rd1_e_i), .rd2_e_i(rd2_e_i),
        .pc_e_i(pc_e_i), .imm_ext_e_i(imm_ext_e_i), .result_m_i(result_m_i),
        .result_w_i(result_w_i), .forward1_e_i(forward1_e_i), .forward2_e_i(forward2_e_i),
        .alu_src_e_i(alu_src_e_i), .alu_control_e_i(alu_control_e_i), .md_en_e_i(md_en_e_i),
        .md_op_e_i(md_op_e_i), .flush_e_i(flush_e_i), .alu_result_e_o(alu_result_e_o),
        .write_data_e_o(write_data_e_o), .pc_target_e_o(pc_target_e_o),
        .zero_e_o(zero_e_o), .stall_e_o(stall_e_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [1:0] c, input logic [31:0] r, m, w);
        return c == 2'd0 ? r : c == 2'd1 ? m : c == 2'd2 ? w : 32'd0;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, b);
        logic signed [31:0] sa;
        sa = a;
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return (a < b) ? 32'd1 : 32'd0;
            4'd7: return a << b[4:0];
            4'd8: return a >> b[4:0];
            4'd9: return sa >>> b[4:0];
            default: return b;
        endcase
    endfunction

    function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, b);
        longint sa, sb, ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        case (op)
            3'd0, 3'd1: p = sa * sb;
            3'd2:       p = sa * ub;
            3'd3:       p = ua * ub;
            3'd4:       p = (b == 0) ? -1 : (a == MIN && b == 32'hFFFF_FFFF) ? sa : sa / sb;
            3'd5:       p = (b == 0) ? -1 : ua / ub;
            3'd6:       p = (b == 0) ? sa : (a == MIN && b == 32'hFFFF_FFFF) ? 0 : sa % sb;
            default:    p = (b == 0) ? ua : ua % ub;
        endcase
        return (op == 3'd1 || op == 3'd2 || op == 3'd3) ? p[63:32] : p[31:0];
    endfunction

    function automatic bit special(input logic [2:0] op, input logic [31:0] a, b);
        return op[2] ? (b == 0 || (!op[0] && a == MIN && b == 32'hFFFF_FFFF)) : (a == 0 || b == 0);
    endfunction

    task automatic md(input string tag, input logic [2:0] op, input logic [31:0] a, b,
                      input bit via_m, input bit keep);
        int n, exp_n;
        @(negedge clk_i);
        md_en_e_i = 1'b1; md_op_e_i = op; alu_src_e_i = 1'b0; flush_e_i = 1'b0;
        forward2_e_i = 2'd0; rd2_e_i = b;
        if (via_m) begin forward1_e_i = 2'd1; result_m_i = a; rd1_e_i = $urandom; end
        else begin forward1_e_i = 2'd0; rd1_e_i = a; end
`ifdef EXEC_MD_EARLY_OUT_EN
        exp_n = special(op, a, b) ? 1 : W + 1;
`else
        exp_n = W + 1;
`endif
        #1;
        n = 0;
        while (stall_e_o && n < 100) begin
            n++;
            @(negedge clk_i);
            rd1_e_i = $urandom; rd2_e_i = $urandom; result_m_i = $urandom;
            result_w_i = $urandom; imm_ext_e_i = $urandom;
            forward1_e_i = 2'($urandom); forward2_e_i = 2'($urandom); alu_src_e_i = 1'($urandom);
            #1;
        end
        check({tag, "_lat"}, n, exp_n);
        check({tag, "_res"}, alu_result_e_o, ref_md(op, a, b));
        if (!keep) begin
            @(negedge clk_i);
            md_en_e_i = 1'b0;
            #1;
            check({tag, "_idle"}, {31'd0, stall_e_o}, 32'd0);
        end
    endtask

    task automatic alu_step(input string tag);
        logic [31:0] s1, wd, s2;
        #1;
        s1 = fwd(forward1_e_i, rd1_e_i, result_m_i, result_w_i);
        wd = fwd(forward2_e_i, rd2_e_i, result_m_i, result_w_i);
        s2 = alu_src_e_i ? imm_ext_e_i : wd;
        check({tag, "_alu"}, alu_result_e_o, ref_alu(alu_control_e_i, s1, s2));
        check({tag, "_wd"}, write_data_e_o, wd);
        check({tag, "_pct"}, pc_target_e_o, pc_e_i + imm_ext_e_i);
        check({tag, "_zero"}, {31'd0, zero_e_o}, {31'd0, s1 == s2});
        check({tag, "_stall"}, {31'd0, stall_e_o}, 32'd0);
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check("reset_stall", {31'd0, stall_e_o}, 32'd0);
        check("reset_alu", alu_result_e_o, 32'd0);

        @(negedge clk_i);
        rd1_e_i = 5; result_m_i = 7; rd2_e_i = 3; forward1_e_i = 2'd1; forward2_e_i = 2'd0;
        alu_control_e_i = 4'd0;
        #1;
        check("fwd_add", alu_result_e_o, 32'd10);
        alu_step("fwd");

        for (int i = 0; i < 16; i++) begin
            @(negedge clk_i);
            rd1_e_i = $urandom; rd2_e_i = (i % 4 == 0) ? rd1_e_i : $urandom;
            result_m_i = $urandom; result_w_i = $urandom; pc_e_i = $urandom; imm_ext_e_i = $urandom;
            forward1_e_i = (i % 4 == 0) ? 2'd0 : 2'($urandom);
            forward2_e_i = (i % 4 == 0) ? 2'd0 : 2'($urandom);
            alu_src_e_i = (i % 4 == 0) ? 1'b0 : 1'($urandom);
            alu_control_e_i = 4'($urandom_range(0, 10));
            alu_step("alu_rand");
        end

        md("mul", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        md("mulh", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
        md("div", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);
        md("rem_b2b", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        md("divu", 3'd5, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        md("div0", 3'd4, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        md("remu0", 3'd7, 32'd9, 32'd0, 1'b0, 1'b0);
        md("rem0n", 3'd6, 32'hFFFF_FFF0, 32'd0, 1'b0, 1'b0);
        md("divovf", 3'd4, MIN, 32'hFFFF_FFFF, 1'b0, 1'b0);
        md("removf", 3'd6, MIN, 32'hFFFF_FFFF, 1'b0, 1'b0);
        md("mul0", 3'd0, 32'd0, 32'd77, 1'b0, 1'b0);
        md("capture", 3'd0, 32'd6, 32'd7, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            op = 3'($urandom); a = $urandom; b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 0;
                1: begin a = MIN; b = 32'hFFFF_FFFF; end
                2: a = 0;
                3: b = $urandom_range(1, 20);
                default: ;
            endcase
            md("md_rand", op, a, b, 1'($urandom), 1'($urandom));
        end

        @(negedge clk_i);
        md_en_e_i = 1'b1; md_op_e_i = 3'd0; rd1_e_i = 3; rd2_e_i = 5;
        forward1_e_i = 2'd0; forward2_e_i = 2'd0; alu_src_e_i = 1'b0; alu_control_e_i = 4'd0;
        #1;
        check("flush_acc", {31'd0, stall_e_o}, 32'd1);
        for (int i = 1; i < 10; i++) @(negedge clk_i);
        @(negedge clk_i);
        flush_e_i = 1'b1;
        #1;
        check("flush_stall", {31'd0, stall_e_o}, 32'd0);
        @(negedge clk_i);
        flush_e_i = 1'b0; md_en_e_i = 1'b0;
        for (int i = 0; i < 36; i++) begin
            #1;
            check("flush_idle_stall", {31'd0, stall_e_o}, 32'd0);
            check("flush_idle_alu", alu_result_e_o, 32'd8);
            @(negedge clk_i);
        end
        md("divu_flush", 3'd5, 32'd100, 32'd7, 1'b0, 1'b0);

        @(negedge clk_i);
        md_en_e_i = 1'b1; md_op_e_i = 3'd4; rd1_e_i = 50; rd2_e_i = 3;
        forward1_e_i = 2'd0; forward2_e_i = 2'd0; alu_src_e_i = 1'b0; alu_control_e_i = 4'd0;
        for (int i = 1; i < 5; i++) @(negedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b1; md_en_e_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 36; i++) begin
            #1;
            check("rst_idle_stall", {31'd0, stall_e_o}, 32'd0);
            check("rst_idle_alu", alu_result_e_o, 32'd53);
            @(negedge clk_i);
        end
        md("divu_rst", 3'd5, 32'd100, 32'd7, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
